nonce_target_checker: RTL and testbench

Post-processing stage directly downstream of the bitcoin hasher. After the hasher has written H0 of the final SHA-256 digest for each nonce to memory, this block:
- reads those NUM_NONCES words back over the shared memory port;
- finds the minimum H0 and its nonce index;
- compares the minimum against a 32-bit target;
- writes a two-word result record to memory and pulses done.

---
 rtl/nonce_target_checker.sv | 132 +++++++++++++
 tb/tb_nonce_target_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_target_checker.sv
// Scans NUM_NONCES H0 words over the shared memory port, keeps the minimum and
// its index, compares it against a target and writes a two-word result record.
module nonce_target_checker #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  nonce_out,
    output logic [31:0] min_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE0 = 3'd2,
        WRITE1 = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [8:0] LP_LAST = 9'(NUM_NONCES);

    state_t      r_state;
    logic [8:0]  r_k;
    logic [15:0] r_hash_addr;
    logic [15:0] r_result_addr;
    logic [31:0] r_target;

    logic        w_take;
    logic [7:0]  w_idx;
    logic [31:0] w_new_min;
    logic [7:0]  w_new_idx;
    logic        w_found;
    logic [15:0] w_next_addr;

    assign mem_clk = clk;

    // Running-minimum update for the word arriving this cycle (index k-1).
    always_comb begin
        w_idx       = 8'(r_k - 9'd1);
        w_take      = (r_k == 9'd1) || (mem_read_data < min_hash);
        w_new_min   = w_take ? mem_read_data : min_hash;
        w_new_idx   = w_take ? w_idx : nonce_out;
        w_found     = (w_new_min < r_target);
        w_next_addr = r_hash_addr + 16'(r_k) + 16'd1;
    end

    // Scan sequencer; every memory-port output is driven from here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_k            <= 9'd0;
            r_hash_addr    <= 16'd0;
            r_result_addr  <= 16'd0;
            r_target       <= 32'd0;
            done           <= 1'b0;
            found          <= 1'b0;
            nonce_out      <= 8'd0;
            min_hash       <= 32'd0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    mem_we <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        r_hash_addr   <= hash_addr;
                        r_result_addr <= result_addr;
                        r_target      <= target;
                        r_k           <= 9'd0;
                        mem_addr      <= hash_addr;
                        r_state       <= READ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                READ: begin
                    // Read data lags its address by one cycle, so capture starts at k=1.
                    if (r_k != 9'd0) begin
                        min_hash  <= w_new_min;
                        nonce_out <= w_new_idx;
                    end else begin
                        min_hash  <= min_hash;
                    end
                    if (r_k == LP_LAST) begin
                        found          <= w_found;
                        mem_we         <= 1'b1;
                        mem_addr       <= r_result_addr;
                        mem_write_data <= {w_found, 23'd0, w_new_idx};
                        r_state        <= WRITE0;
                    end else begin
                        r_k      <= r_k + 9'd1;
                        mem_addr <= w_next_addr;
                    end
                end
                WRITE0: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= r_result_addr + 16'd1;
                    mem_write_data <= min_hash;
                    r_state        <= WRITE1;
                end
                WRITE1: begin
                    mem_we  <= 1'b0;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    mem_we  <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_target_checker.sv
// Randomised bench for nonce_target_checker: a cycle-schedule model with a
// memory model, checked every cycle, plus fixed-value scenarios.
module tb_nonce_target_checker;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [7:0]  nonce_out;
    logic [31:0] min_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];

    int checks = 0;
    int failures = 0;

    nonce_target_checker #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done), .found(found), .nonce_out(nonce_out), .min_hash(min_hash),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: one-cycle read latency, write on we.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position and expected result record.
    bit          armed = 0;
    bit          busy = 0;
    int          c = 0;
    logic [15:0] e_h, e_r;
    logic [31:0] e_min;
    logic [7:0]  e_idx;
    logic        e_found;
    logic [31:0] w;

    always @(posedge clk) begin
        if (!reset_n) begin
            armed = 1; busy = 0; c = 0;
            e_min = 32'd0; e_idx = 8'd0; e_found = 1'b0;
        end else if (busy) begin
            c++;
            if (c == N + 4) busy = 0;
        end else if (start && armed) begin
            busy = 1; c = 0;
            e_h = hash_addr; e_r = result_addr;
            for (int i = 0; i < N; i++) begin
                w = mem[e_h + 16'(i)];
                if (i == 0 || w < e_min) begin
                    e_min = w;
                    e_idx = 8'(i);
                end
            end
            e_found = (e_min < target);
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, busy && (c == N + 1 || c == N + 2)});
            chk("done", {31'd0, done}, {31'd0, busy && (c == N + 3)});
            if (busy && c < N) chk("read_addr", {16'd0, mem_addr}, {16'd0, 16'(e_h + 16'(c))});
            if (busy && c == N + 1) begin
                chk("w0_addr", {16'd0, mem_addr}, {16'd0, e_r});
                chk("w0_data", mem_write_data, {e_found, 23'd0, e_idx});
            end
            if (busy && c == N + 2) begin
                chk("w1_addr", {16'd0, mem_addr}, {16'd0, 16'(e_r + 16'd1)});
                chk("w1_data", mem_write_data, e_min);
            end
            if (!busy || c > N) begin
                chk("found", {31'd0, found}, {31'd0, e_found});
                chk("nonce_out", {24'd0, nonce_out}, {24'd0, e_idx});
                chk("min_hash", min_hash, e_min);
            end
        end
    end

    // Launch a scan and return cycles from the start edge to the edge sampling done=1.
    task automatic do_scan(input logic [15:0] h, input logic [15:0] r,
                           input logic [31:0] t, output int lat);
        int n;
        @(negedge clk);
        hash_addr = h; result_addr = r; target = t; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=none required=pulse");
        end
        lat = n + 1;
    endtask

    int lat;
    int dcount;

    initial begin
        reset_n = 1'b0; start = 1'b0;
        hash_addr = 16'd0; result_addr = 16'd0; target = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        chk("rst_min", min_hash, 32'd0);
        chk("rst_nonce", {24'd0, nonce_out}, 32'd0);

        // Ascending data.
        for (int i = 0; i < N; i++) mem[16'h0100 + 16'(i)] = 32'h1000_0000 + 32'(i);
        do_scan(16'h0100, 16'h0200, 32'h1000_0001, lat);
        chk("latency", 32'(lat), 32'd20);
        chk("asc_rec0", mem[16'h0200], 32'h8000_0000);
        chk("asc_rec1", mem[16'h0201], 32'h1000_0000);

        // Minimum in the middle, equal to target.
        for (int i = 0; i < N; i++) mem[16'h0300 + 16'(i)] = 32'hFFFF_FFFF;
        mem[16'h0309] = 32'h0000_00FF;
        do_scan(16'h0300, 16'h0400, 32'h0000_00FF, lat);
        chk("mid_found", {31'd0, found}, 32'd0);
        chk("mid_nonce", {24'd0, nonce_out}, 32'd9);
        chk("mid_min", min_hash, 32'h0000_00FF);
        chk("mid_rec0", mem[16'h0400], 32'h0000_0009);

        // Tie keeps the lower index.
        for (int i = 0; i < N; i++) mem[16'h0500 + 16'(i)] = 32'h0000_0020;
        mem[16'h0503] = 32'h0000_0010;
        mem[16'h050C] = 32'h0000_0010;
        do_scan(16'h0500, 16'h0600, 32'hFFFF_FFFF, lat);
        chk("tie_nonce", {24'd0, nonce_out}, 32'd3);
        chk("tie_found", {31'd0, found}, 32'd1);

        // Address wrap on both reads and result writes.
        for (int i = 0; i < N; i++) mem[16'hFFF8 + 16'(i)] = 32'h0000_1000 + 32'(i * 3);
        mem[16'h0002] = 32'h0000_0005;
        do_scan(16'hFFF8, 16'hFFFF, 32'h0000_0006, lat);
        chk("wrap_rec0", mem[16'hFFFF], 32'h8000_000A);
        chk("wrap_rec1", mem[16'h0000], 32'h0000_0005);

        // Reset during READ cycle 5, then a fresh scan.
        for (int i = 0; i < N; i++) mem[16'h0700 + 16'(i)] = $urandom;
        @(negedge clk);
        hash_addr = 16'h0700; result_addr = 16'h0800; target = 32'h8000_0000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mrst_min", min_hash, 32'd0);
        chk("mrst_nonce", {24'd0, nonce_out}, 32'd0);
        chk("mrst_found", {31'd0, found}, 32'd0);
        chk("mrst_addr", {16'd0, mem_addr}, 32'd0);
        repeat (30) @(negedge clk);
        mem[16'h0704] = 32'd0;
        do_scan(16'h0700, 16'h0800, 32'd1, lat);
        chk("mrst_rec0", mem[16'h0800], 32'h8000_0004);

        // start held through WRITE0..DONE is ignored.
        dcount = 0;
        @(negedge clk);
        hash_addr = 16'h0100; result_addr = 16'h0200; target = 32'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 60; n++) begin
            @(negedge clk);
            start = (n >= N + 1 && n <= N + 3);
            if (done) dcount++;
        end
        start = 1'b0;
        chk("one_done", 32'(dcount), 32'd1);

        // Randomised scans.
        for (int s = 0; s < 20; s++) begin
            logic [15:0] h;
            logic [31:0] t;
            h = 16'($urandom);
            for (int i = 0; i < N; i++)
                mem[h + 16'(i)] = (s % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            t = (s % 2 == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            do_scan(h, h + 16'(N) + 16'($urandom_range(0, 100)), t, lat);
            chk("rand_latency", 32'(lat), 32'(N + 4));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
